// File: rtl/fe_pkg.sv
// Front-end shared types: RV32I mnemonic enum used by
// the decode path and the run-time instruction encoder.
package fe_pkg;

    typedef enum logic [5:0] {
        NULL,
        LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI,
        SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU,
        XOR, SRL, SRA, OR, AND,
        ECALL, EBREAK
    } RV32I_INSTRUCTION_MNEMONIC_t;

endpackage

// File: rtl/fe_instr_encoder.sv
// Streaming RV32I encoder: mnemonic + fields -> machine word,
// tagged with an auto-incrementing IMEM address, via a small FIFO.
module fe_instr_encoder
    import fe_pkg::*;
#(
    parameter int              ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int              FIFO_DEPTH = 2,
    parameter int              ERR_CNT_W  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  RV32I_INSTRUCTION_MNEMONIC_t in_mnem,
    input  logic [4:0]                  in_rd,
    input  logic [4:0]                  in_rs1,
    input  logic [4:0]                  in_rs2,
    input  logic [31:0]                 in_imm,
    input  logic                        addr_load,
    input  logic [ADDR_W-1:0]           addr_val,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [31:0]                 out_word,
    output logic [ADDR_W-1:0]           out_addr,
    output logic                        err_pulse,
    output logic [ERR_CNT_W-1:0]        err_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [3:0] {
        F_NONE, F_R, F_I, F_SH, F_ENV, F_S, F_B, F_J, F_U
    } fmt_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYS    = 7'b1110011;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    fmt_t       fmt;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;

    always_comb begin
        fmt = F_NONE;
        opc = '0;
        f3  = '0;
        f7  = '0;
        unique case (in_mnem)
            LUI:    begin fmt = F_U; opc = OP_LUI;   end
            AUIPC:  begin fmt = F_U; opc = OP_AUIPC; end
            JAL:    begin fmt = F_J; opc = OP_JAL;   end
            JALR:   begin fmt = F_I; opc = OP_JALR;  end
            BEQ:    begin fmt = F_B; opc = OP_BRANCH; f3 = 3'd0; end
            BNE:    begin fmt = F_B; opc = OP_BRANCH; f3 = 3'd1; end
            BLT:    begin fmt = F_B; opc = OP_BRANCH; f3 = 3'd4; end
            BGE:    begin fmt = F_B; opc = OP_BRANCH; f3 = 3'd5; end
            BLTU:   begin fmt = F_B; opc = OP_BRANCH; f3 = 3'd6; end
            BGEU:   begin fmt = F_B; opc = OP_BRANCH; f3 = 3'd7; end
            LB:     begin fmt = F_I; opc = OP_LOAD;  f3 = 3'd0; end
            LH:     begin fmt = F_I; opc = OP_LOAD;  f3 = 3'd1; end
            LW:     begin fmt = F_I; opc = OP_LOAD;  f3 = 3'd2; end
            LBU:    begin fmt = F_I; opc = OP_LOAD;  f3 = 3'd4; end
            LHU:    begin fmt = F_I; opc = OP_LOAD;  f3 = 3'd5; end
            SB:     begin fmt = F_S; opc = OP_STORE; f3 = 3'd0; end
            SH:     begin fmt = F_S; opc = OP_STORE; f3 = 3'd1; end
            SW:     begin fmt = F_S; opc = OP_STORE; f3 = 3'd2; end
            ADDI:   begin fmt = F_I; opc = OP_IMM; f3 = 3'd0; end
            SLTI:   begin fmt = F_I; opc = OP_IMM; f3 = 3'd2; end
            SLTIU:  begin fmt = F_I; opc = OP_IMM; f3 = 3'd3; end
            XORI:   begin fmt = F_I; opc = OP_IMM; f3 = 3'd4; end
            ORI:    begin fmt = F_I; opc = OP_IMM; f3 = 3'd6; end
            ANDI:   begin fmt = F_I; opc = OP_IMM; f3 = 3'd7; end
            SLLI:   begin fmt = F_SH; opc = OP_IMM; f3 = 3'd1; end
            SRLI:   begin fmt = F_SH; opc = OP_IMM; f3 = 3'd5; end
            SRAI:   begin fmt = F_SH; opc = OP_IMM; f3 = 3'd5; f7 = F7_ALT; end
            ADD:    begin fmt = F_R; opc = OP_REG; f3 = 3'd0; end
            SUB:    begin fmt = F_R; opc = OP_REG; f3 = 3'd0; f7 = F7_ALT; end
            SLL:    begin fmt = F_R; opc = OP_REG; f3 = 3'd1; end
            SLT:    begin fmt = F_R; opc = OP_REG; f3 = 3'd2; end
            SLTU:   begin fmt = F_R; opc = OP_REG; f3 = 3'd3; end
            XOR:    begin fmt = F_R; opc = OP_REG; f3 = 3'd4; end
            SRL:    begin fmt = F_R; opc = OP_REG; f3 = 3'd5; end
            SRA:    begin fmt = F_R; opc = OP_REG; f3 = 3'd5; f7 = F7_ALT; end
            OR:     begin fmt = F_R; opc = OP_REG; f3 = 3'd6; end
            AND:    begin fmt = F_R; opc = OP_REG; f3 = 3'd7; end
            ECALL:  begin fmt = F_ENV; opc = OP_SYS; end
            EBREAK: begin fmt = F_ENV; opc = OP_SYS; end
            default: fmt = F_NONE;
        endcase
    end

    // Range checks reduce to "upper bits are pure sign extension"
    logic imm12_ok, sh_ok, b_ok, j_ok, u_ok, env_b;

    assign imm12_ok = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
    assign sh_ok    = (in_imm[31:5] == '0);
    assign b_ok     = ((in_imm[31:12] == '0) || (in_imm[31:12] == '1))
                      && !in_imm[0];
    assign j_ok     = ((in_imm[31:20] == '0) || (in_imm[31:20] == '1))
                      && !in_imm[0];
    assign u_ok     = (in_imm[11:0] == '0);
    assign env_b    = (in_mnem == EBREAK);

    logic [31:0] word;
    logic        legal;

    always_comb begin
        word  = '0;
        legal = 1'b0;
        unique case (fmt)
            F_R: begin
                word  = {f7, in_rs2, in_rs1, f3, in_rd, opc};
                legal = 1'b1;
            end
            F_I: begin
                word  = {in_imm[11:0], in_rs1, f3, in_rd, opc};
                legal = imm12_ok;
            end
            F_SH: begin
                word  = {f7, in_imm[4:0], in_rs1, f3, in_rd, opc};
                legal = sh_ok;
            end
            F_ENV: begin
                word  = {11'b0, env_b, 13'b0, opc};
                legal = 1'b1;
            end
            F_S: begin
                word  = {in_imm[11:5], in_rs2, in_rs1, f3,
                         in_imm[4:0], opc};
                legal = imm12_ok;
            end
            F_B: begin
                word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3,
                         in_imm[4:1], in_imm[11], opc};
                legal = b_ok;
            end
            F_J: begin
                word  = {in_imm[20], in_imm[10:1], in_imm[11],
                         in_imm[19:12], in_rd, opc};
                legal = j_ok;
            end
            F_U: begin
                word  = {in_imm[31:12], in_rd, opc};
                legal = u_ok;
            end
            F_NONE: begin
                word  = '0;
                legal = 1'b0;
            end
        endcase
    end

    logic [31:0]       mem_word [FIFO_DEPTH];
    logic [ADDR_W-1:0] mem_addr [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] addr_cnt;
    logic              accept, push, pop;

    assign in_ready  = rst_n && (count < DEPTH_C);
    assign out_valid = (count != '0);
    assign out_word  = mem_word[rd_ptr];
    assign out_addr  = mem_addr[rd_ptr];
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_word[i] <= '0;
                mem_addr[i] <= '0;
            end
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            addr_cnt  <= BASE_ADDR;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            if (push) begin
                mem_word[wr_ptr] <= word;
                mem_addr[wr_ptr] <= addr_cnt;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && pop) begin
                count <= count - CNT_W'(1);
            end
            // A load wins over the increment; the entry keeps the old tag
            if (addr_load) begin
                addr_cnt <= addr_val;
            end else if (push) begin
                addr_cnt <= addr_cnt + ADDR_W'(4);
            end
            err_pulse <= accept && !legal;
            if (accept && !legal && (err_count != '1)) begin
                err_count <= err_count + ERR_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fe_instr_encoder.sv
// Scoreboard bench for fe_instr_encoder: expected words/addresses
// are queued at drive time and popped on each output handshake.
module tb_fe_instr_encoder;
    import fe_pkg::*;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        in_valid;
    logic                        in_ready;
    RV32I_INSTRUCTION_MNEMONIC_t in_mnem;
    logic [4:0]                  in_rd, in_rs1, in_rs2;
    logic [31:0]                 in_imm;
    logic                        addr_load;
    logic [31:0]                 addr_val;
    logic                        out_valid;
    logic                        out_ready;
    logic [31:0]                 out_word;
    logic [31:0]                 out_addr;
    logic                        err_pulse;
    logic [7:0]                  err_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [63:0] exp_q[$];
    int          pop_cyc[$];
    logic [31:0] exp_addr;
    logic [7:0]  exp_err;

    fe_instr_encoder #(
        .ADDR_W(32),
        .BASE_ADDR(32'h0000_0000),
        .FIFO_DEPTH(2),
        .ERR_CNT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_mnem(in_mnem),
        .in_rd(in_rd),
        .in_rs1(in_rs1),
        .in_rs2(in_rs2),
        .in_imm(in_imm),
        .addr_load(addr_load),
        .addr_val(addr_val),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_word(out_word),
        .out_addr(out_addr),
        .err_pulse(err_pulse),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Handshake decided at the negedge completes on the next posedge
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got word=%h addr=%h",
                         out_word, out_addr);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({out_word, out_addr} !== e) begin
                    errors++;
                    $display("FAIL out_entry: got word=%h addr=%h exp word=%h addr=%h",
                             out_word, out_addr, e[63:32], e[31:0]);
                end
            end
            pop_cyc.push_back(cyc);
        end
    end

    task automatic send(input RV32I_INSTRUCTION_MNEMONIC_t m,
                        input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm,
                        input logic [31:0] w, input bit legal);
        int n = 0;
        in_valid = 1'b1;
        in_mnem  = m;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_imm   = imm;
        if (legal) begin
            exp_q.push_back({w, exp_addr});
            exp_addr = exp_addr + 32'd4;
        end
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b exp 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d exp 0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        exp_addr = 32'h0;
        exp_err  = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_mnem   = NULL;
        in_rd     = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_imm    = '0;
        addr_load = 1'b0;
        addr_val  = '0;
        out_ready = 1'b1;
        exp_addr  = 32'h0;
        exp_err   = 8'd0;
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b exp 0 0",
                     in_ready, out_valid);
        end
        checks++;
        if (out_word !== 32'h0 || out_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: word=%h addr=%h exp 0 0",
                     out_word, out_addr);
        end
        checks++;
        if (err_pulse !== 1'b0 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_err: pulse=%b count=%0d exp 0 0",
                     err_pulse, err_count);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: in_ready=%b exp 1", in_ready);
        end
    endtask

    task automatic test_addi();
        send(ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_word !== 32'h0050_0093
            || out_addr !== 32'h0) begin
            errors++;
            $display("FAIL addi_latency: v=%b word=%h addr=%h exp 1 00500093 0",
                     out_valid, out_word, out_addr);
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        do_reset();
        pop_cyc.delete();
        send(ADD,  5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3, 1'b1);
        send(SUB,  5'd3, 5'd1, 5'd2, 32'd0, 32'h4020_81B3, 1'b1);
        send(SRAI, 5'd1, 5'd2, 5'd0, 32'd3, 32'h4031_5093, 1'b1);
        wait_drain();
        checks++;
        if (pop_cyc.size() != 3) begin
            errors++;
            $display("FAIL b2b_count: pops=%0d exp 3", pop_cyc.size());
        end else if (pop_cyc[2] - pop_cyc[0] != 2) begin
            errors++;
            $display("FAIL b2b_bubbles: span=%0d exp 2",
                     pop_cyc[2] - pop_cyc[0]);
        end
    endtask

    task automatic test_formats();
        send(BEQ,    5'd0, 5'd1, 5'd2, 32'd8,        32'h0020_8463, 1'b1);
        send(JAL,    5'd1, 5'd0, 5'd0, 32'd2048,     32'h0010_00EF, 1'b1);
        send(LUI,    5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b1);
        send(ECALL,  5'd5, 5'd3, 5'd7, 32'd0,        32'h0000_0073, 1'b1);
        send(EBREAK, 5'd0, 5'd0, 5'd0, 32'd0,        32'h0010_0073, 1'b1);
        send(SW,     5'd0, 5'd2, 5'd3, -32'sd4,      32'hFE31_2E23, 1'b1);
        send(LW,     5'd5, 5'd2, 5'd0, 32'd8,        32'h0081_2283, 1'b1);
        send(AUIPC,  5'd1, 5'd0, 5'd0, 32'h0000_1000, 32'h0000_1097, 1'b1);
        send(ADDI,   5'd1, 5'd0, 5'd0, 32'd2047,     32'h7FF0_0093, 1'b1);
        send(ADDI,   5'd1, 5'd0, 5'd0, -32'sd2048,   32'h8000_0093, 1'b1);
        send(SLLI,   5'd1, 5'd1, 5'd0, 32'd31,       32'h01F0_9093, 1'b1);
        send(JAL,    5'd0, 5'd0, 5'd0, -32'sd4,      32'hFFDF_F06F, 1'b1);
        wait_drain();
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        send(ADDI, 5'd1, 5'd0, 5'd0, 32'd1, 32'h0010_0093, 1'b1);
        send(ADDI, 5'd1, 5'd0, 5'd0, 32'd2, 32'h0020_0093, 1'b1);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_ready: in_ready=%b exp 0", in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_word !== 32'h0010_0093) begin
                errors++;
                $display("FAIL stall_hold: v=%b word=%h exp 1 00100093",
                         out_valid, out_word);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(ADDI, 5'd1, 5'd0, 5'd0, 32'd3, 32'h0030_0093, 1'b1);
        wait_drain();
    endtask

    task automatic test_illegal();
        RV32I_INSTRUCTION_MNEMONIC_t m [6];
        logic [31:0] imm [6];
        m[0] = ADDI;   imm[0] = 32'd2048;
        m[1] = BEQ;    imm[1] = 32'd3;
        m[2] = LUI;    imm[2] = 32'h0000_1001;
        m[3] = NULL;   imm[3] = 32'd0;
        m[4] = SRAI;   imm[4] = 32'd32;
        m[5] = JAL;    imm[5] = 32'd1048576;
        for (int i = 0; i < 6; i++) begin
            send(m[i], 5'd1, 5'd1, 5'd1, imm[i], 32'h0, 1'b0);
            exp_err = exp_err + 8'd1;
            checks++;
            if (err_pulse !== 1'b1 || err_count !== exp_err
                || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL illegal_%0d: pulse=%b count=%0d v=%b exp 1 %0d 0",
                         i, err_pulse, err_count, out_valid, exp_err);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (err_pulse !== 1'b0) begin
            errors++;
            $display("FAIL illegal_pulse_end: pulse=%b exp 0", err_pulse);
        end
        send(ADDI, 5'd2, 5'd0, 5'd0, 32'd7, 32'h0070_0113, 1'b1);
        wait_drain();
    endtask

    task automatic test_addr_wrap();
        addr_load = 1'b1;
        addr_val  = 32'hFFFF_FFFC;
        send(ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b1);
        addr_load = 1'b0;
        exp_addr  = 32'hFFFF_FFFC;
        send(ADD, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3, 1'b1);
        send(SUB, 5'd3, 5'd1, 5'd2, 32'd0, 32'h4020_81B3, 1'b1);
        wait_drain();
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        send(ADDI, 5'd1, 5'd0, 5'd0, 32'd1, 32'h0010_0093, 1'b1);
        send(ADDI, 5'd1, 5'd0, 5'd0, 32'd2, 32'h0020_0093, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_hs: v=%b in_ready=%b exp 0 0",
                     out_valid, in_ready);
        end
        checks++;
        if (out_word !== 32'h0 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL mid_reset_state: word=%h errs=%0d exp 0 0",
                     out_word, err_count);
        end
        exp_q.delete();
        exp_addr = 32'h0;
        exp_err  = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_flush: v=%b exp 0", out_valid);
        end
        send(ADDI, 5'd4, 5'd0, 5'd0, 32'd9, 32'h0090_0213, 1'b1);
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_formats();
        test_stall();
        test_illegal();
        test_addr_wrap();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
